uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arbiter.sv | 96 +++++++++
 tb/tb_uart_tx_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among four byte requesters.
// A grant is followed by a one-cycle trigger and a full frame-plus-guard wait.
module uart_tx_arbiter #(
    parameter int BAUD_END  = 5207,
    parameter int GUARD_CYC = 16
) (
    input  logic        sclk,
    input  logic        s_rst_n,
    input  logic [3:0]  req_valid,
    input  logic [31:0] req_data,
    output logic [3:0]  req_ready,
    output logic        tx_trig,
    output logic [7:0]  tx_data,
    output logic [1:0]  grant_id,
    output logic        busy,
    output logic        frame_done
);

    localparam int FRAME_CYC = (BAUD_END + 1) * 10 + GUARD_CYC;
    localparam logic [15:0] LAST_CNT = 16'(FRAME_CYC - 1);
    localparam logic [15:0] PRE_LAST = 16'(FRAME_CYC - 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TRIG = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t      state;
    logic [15:0] wait_cnt;
    logic        pick_valid;
    logic [1:0]  pick;
    logic [1:0]  idx;

    // grant_id doubles as the round-robin pointer; scanning from the far end
    // lets the nearest requester after the last grant overwrite the others.
    always_comb begin
        pick_valid = 1'b0;
        pick       = grant_id;
        idx        = grant_id;
        for (int i = 4; i >= 1; i--) begin
            idx = grant_id + 2'(i);
            if (req_valid[idx]) begin
                pick_valid = 1'b1;
                pick       = idx;
            end
        end
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state      <= IDLE;
            wait_cnt   <= 16'd0;
            req_ready  <= 4'b0000;
            tx_trig    <= 1'b0;
            tx_data    <= 8'h00;
            grant_id   <= 2'd3;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    frame_done <= 1'b0;
                    if (pick_valid) begin
                        tx_data   <= req_data[{pick, 3'b000} +: 8];
                        grant_id  <= pick;
                        req_ready <= 4'b0001 << pick;
                        tx_trig   <= 1'b1;
                        busy      <= 1'b1;
                        state     <= TRIG;
                    end
                end
                TRIG: begin
                    req_ready <= 4'b0000;
                    tx_trig   <= 1'b0;
                    wait_cnt  <= 16'd0;
                    state     <= WAIT;
                end
                WAIT: begin
                    // frame_done is registered, so it is raised one edge early
                    // to coincide with the cycle where the counter hits its end.
                    if (wait_cnt == LAST_CNT) begin
                        frame_done <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        wait_cnt   <= wait_cnt + 16'd1;
                        frame_done <= (wait_cnt == PRE_LAST);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus random traffic, all checked
// every cycle against a timeline model of grants, triggers and frame windows.
module tb_uart_tx_arbiter;

    localparam int BE    = 3;
    localparam int GC    = 2;
    localparam int FRAME = (BE + 1) * 10 + GC;

    logic        sclk;
    logic        s_rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        tx_trig;
    logic [7:0]  tx_data;
    logic [1:0]  grant_id;
    logic        busy;
    logic        frame_done;

    uart_tx_arbiter #(.BAUD_END(BE), .GUARD_CYC(GC)) dut (
        .sclk(sclk), .s_rst_n(s_rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tx_trig(tx_trig), .tx_data(tx_data),
        .grant_id(grant_id), .busy(busy), .frame_done(frame_done)
    );

    initial begin
        sclk = 1'b0;
        forever #5 sclk = ~sclk;
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // model: when the last grant's trigger appears and when arbitration reopens
    int         trig_at;
    int         next_ok;
    logic [7:0] m_data;
    logic [1:0] m_gid;
    logic [7:0] exp_q[$];

    // requesters and observation logs
    logic [7:0] src_q[4][$];
    bit         ignore_rdy[4];
    bit         req_en;
    bit         rand_mode;
    int         trig_cyc_q[$];
    logic [7:0] trig_dat_q[$];
    logic [1:0] trig_gid_q[$];
    int         ready_cnt[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        trig_at = -1;
        next_ok = 0;
        m_data  = 8'h00;
        m_gid   = 2'd3;
        exp_q.delete();
    endtask

    task automatic clear_logs();
        trig_cyc_q.delete();
        trig_dat_q.delete();
        trig_gid_q.delete();
        for (int k = 0; k < 4; k++) ready_cnt[k] = 0;
    endtask

    task automatic compare();
        bit         t_now;
        logic [3:0] er;
        logic [7:0] eb;
        t_now = (trig_at >= 0) && (cyc == trig_at);
        er    = t_now ? (4'b0001 << m_gid) : 4'b0000;
        check("tx_trig", {31'd0, tx_trig}, {31'd0, t_now});
        check("req_ready", {28'd0, req_ready}, {28'd0, er});
        check("busy", {31'd0, busy},
              {31'd0, (trig_at >= 0) && (cyc >= trig_at) && (cyc <= trig_at + FRAME)});
        check("frame_done", {31'd0, frame_done},
              {31'd0, (trig_at >= 0) && (cyc == trig_at + FRAME)});
        check("tx_data", {24'd0, tx_data}, {24'd0, m_data});
        check("grant_id", {30'd0, grant_id}, {30'd0, m_gid});
        for (int k = 0; k < 4; k++) if (req_ready[k] === 1'b1) ready_cnt[k]++;
        if (tx_trig === 1'b1) begin
            trig_cyc_q.push_back(cyc);
            trig_dat_q.push_back(tx_data);
            trig_gid_q.push_back(grant_id);
            if (exp_q.size() == 0) begin
                check("sb_unexpected_trig", 32'd1, 32'd0);
            end else begin
                eb = exp_q.pop_front();
                check("sb_byte", {24'd0, tx_data}, {24'd0, eb});
            end
        end
    endtask

    task automatic drive();
        logic [3:0]  v;
        logic [31:0] d;
        v = 4'b0000;
        d = 32'd0;
        for (int k = 0; k < 4; k++) begin
            if (req_ready[k] === 1'b1 && !ignore_rdy[k] && src_q[k].size() > 0)
                void'(src_q[k].pop_front());
            else if (rand_mode && src_q[k].size() > 0 && $urandom_range(0, 199) == 0)
                void'(src_q[k].pop_front());
            if (rand_mode && src_q[k].size() < 3 && $urandom_range(0, 29) == 0)
                src_q[k].push_back(8'($urandom_range(0, 255)));
            if (req_en && src_q[k].size() > 0) begin
                v[k]         = 1'b1;
                d[8*k +: 8]  = src_q[k][0];
            end
        end
        req_valid = v;
        req_data  = d;
    endtask

    task automatic model_step();
        int k;
        if (cyc >= next_ok && req_valid != 4'b0000) begin
            k = -1;
            for (int i = 1; i <= 4; i++) begin
                if (k < 0 && req_valid[(int'(m_gid) + i) % 4]) k = (int'(m_gid) + i) % 4;
            end
            m_gid   = 2'(k);
            m_data  = req_data[8*k +: 8];
            trig_at = cyc + 1;
            next_ok = cyc + FRAME + 2;
            exp_q.push_back(m_data);
        end
    endtask

    task automatic tick();
        @(negedge sclk);
        cyc++;
        compare();
        drive();
        model_step();
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while ((busy !== 1'b0 || req_valid != 4'b0000) && n < limit) begin
            tick();
            n++;
        end
        check("idle_timeout", {31'd0, n < limit}, 32'd1);
        tick();
    endtask

    task automatic wait_trigs(input int cnt, input int limit);
        int n;
        n = 0;
        while (trig_cyc_q.size() < cnt && n < limit) begin
            tick();
            n++;
        end
        check("trig_timeout", {31'd0, trig_cyc_q.size() >= cnt}, 32'd1);
    endtask

    initial begin
        int t0;
        int busy_n;
        int fd_cyc;
        s_rst_n   = 1'b0;
        req_valid = 4'b0000;
        req_data  = 32'd0;
        req_en    = 1'b0;
        rand_mode = 1'b0;
        for (int k = 0; k < 4; k++) ignore_rdy[k] = 1'b0;
        model_reset();
        clear_logs();
        repeat (3) tick();
        s_rst_n = 1'b1;
        tick();
        req_en = 1'b1;

        // idle after reset
        repeat (100) tick();
        check("idle_no_trig", trig_cyc_q.size(), 32'd0);
        check("idle_no_ready", ready_cnt[0] + ready_cnt[1] + ready_cnt[2] + ready_cnt[3], 32'd0);
        check("idle_tx_data", {24'd0, tx_data}, 32'h00);
        check("idle_busy", {31'd0, busy}, 32'd0);

        // all four pending: 0,1,2,3 spaced FRAME+2
        clear_logs();
        src_q[0].push_back(8'h10);
        src_q[1].push_back(8'h21);
        src_q[2].push_back(8'h32);
        src_q[3].push_back(8'h43);
        wait_trigs(4, 250);
        if (trig_cyc_q.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                check("rr_gid", {30'd0, trig_gid_q[i]}, i);
                check("rr_data", {24'd0, trig_dat_q[i]}, 32'h10 + 32'h11 * i);
                if (i > 0) check("rr_spacing", trig_cyc_q[i] - trig_cyc_q[i-1], 32'd44);
            end
        end
        wait_idle(200);
        for (int k = 0; k < 4; k++) check("rr_ready_once", ready_cnt[k], 32'd1);

        // single byte from requester 0
        clear_logs();
        src_q[0].push_back(8'hA5);
        tick();
        tick();
        check("t1_trig", {31'd0, tx_trig}, 32'd1);
        check("t1_data", {24'd0, tx_data}, 32'hA5);
        check("t1_ready", {28'd0, req_ready}, 32'b0001);
        check("t1_gid", {30'd0, grant_id}, 32'd0);
        t0 = cyc;
        busy_n = (busy === 1'b1) ? 1 : 0;
        fd_cyc = -1;
        repeat (60) begin
            tick();
            if (busy === 1'b1) busy_n++;
            if (frame_done === 1'b1) fd_cyc = cyc;
        end
        check("t1_busy_len", busy_n, 32'd43);
        check("t1_done_pos", fd_cyc - t0, 32'd42);

        // requester ignoring ready: one trigger per 44 cycles
        clear_logs();
        ignore_rdy[0] = 1'b1;
        src_q[0].push_back(8'h5A);
        repeat (140) tick();
        check("t4_trig_cnt", trig_cyc_q.size(), 32'd4);
        check("t4_ready_cnt", ready_cnt[0], 32'd4);
        for (int i = 1; i < trig_cyc_q.size(); i++)
            check("t4_spacing", trig_cyc_q[i] - trig_cyc_q[i-1], 32'd44);
        ignore_rdy[0] = 1'b0;
        src_q[0].delete();
        wait_idle(200);

        // reset in the middle of WAIT
        clear_logs();
        src_q[1].push_back(8'h77);
        wait_trigs(1, 10);
        t0 = (trig_cyc_q.size() > 0) ? trig_cyc_q[0] : cyc;
        while (cyc < t0 + 21) tick();
        s_rst_n = 1'b0;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_trig", {31'd0, tx_trig}, 32'd0);
        check("rst_ready", {28'd0, req_ready}, 32'd0);
        check("rst_data", {24'd0, tx_data}, 32'h00);
        check("rst_gid", {30'd0, grant_id}, 32'd3);
        check("rst_done", {31'd0, frame_done}, 32'd0);
        model_reset();
        req_en = 1'b0;
        repeat (3) tick();
        s_rst_n = 1'b1;
        clear_logs();
        src_q[2].push_back(8'h5C);
        req_en = 1'b1;
        fd_cyc = -1;
        repeat (50) begin
            tick();
            if (frame_done === 1'b1) fd_cyc = cyc;
        end
        check("t5_trig_cnt", trig_cyc_q.size(), 32'd1);
        if (trig_cyc_q.size() > 0) begin
            check("t5_gid", {30'd0, trig_gid_q[0]}, 32'd2);
            check("t5_data", {24'd0, trig_dat_q[0]}, 32'h5C);
            check("t5_wait_len", fd_cyc - trig_cyc_q[0], 32'd42);
        end
        wait_idle(200);

        // fairness: req1 held, req3 arrives mid-frame
        clear_logs();
        for (int i = 0; i < 4; i++) src_q[1].push_back(8'h11 + 8'(i));
        wait_trigs(1, 10);
        t0 = (trig_cyc_q.size() > 0) ? trig_cyc_q[0] : cyc;
        while (cyc < t0 + 20) tick();
        src_q[3].push_back(8'h33);
        wait_trigs(3, 120);
        if (trig_cyc_q.size() >= 3) begin
            check("t3_first", {30'd0, trig_gid_q[0]}, 32'd1);
            check("t3_second", {30'd0, trig_gid_q[1]}, 32'd3);
            check("t3_third", {30'd0, trig_gid_q[2]}, 32'd1);
            check("t3_byte3", {24'd0, trig_dat_q[1]}, 32'h33);
        end
        wait_idle(400);

        // random traffic, including occasional withdrawn requests
        rand_mode = 1'b1;
        repeat (2500) tick();
        rand_mode = 1'b0;
        for (int k = 0; k < 4; k++) src_q[k].delete();
        wait_idle(200);
        check("sb_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
